muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer for the Execute stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operations from ID/EX and runs a radix-2 shift-add multiply or a restoring divide over 32 iterations. It writes the HI/LO register pair and raises a stall request so the hazard logic can hold the pipeline while a result is pending.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 124 ++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*XLEN register.
module muldiv_step #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);
  logic [XLEN:0] sum;
  logic [XLEN:0] top;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    // Remainder after the left shift needs one extra bit before the compare.
    top      = acc[2*XLEN-1:XLEN-1];
    diff     = top - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      if (top >= {1'b0, operand}) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                        acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// MIPS Execute-stage multiply/divide sequencer: 32 iterations plus a sign-fix cycle into HI/LO.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  input  logic            hilo_rd,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import muldiv_pkg::*;

  state_e                state;
  op_e                   op_q;
  logic                  sign_a;
  logic                  sign_b;
  logic                  div_zero;
  logic [CNT_W-1:0]      cnt;
  logic [2*XLEN-1:0]     acc;
  logic [XLEN-1:0]       operand;
  logic [2*XLEN-1:0]     acc_next;
  logic                  is_div;
  logic                  op_signed;
  logic                  accept;
  logic [XLEN-1:0]       mag_a;
  logic [XLEN-1:0]       mag_b;
  logic [XLEN-1:0]       res_hi;
  logic [XLEN-1:0]       res_lo;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic take_abs);
    return (take_abs && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_if(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign op_signed = ~op[0];
  assign is_div    = op_q[1];
  assign accept    = (state == IDLE) && start && !flush;
  assign mag_a     = magnitude(rs_val, op_signed);
  assign mag_b     = magnitude(rt_val, op_signed);
  assign busy      = (state != IDLE);
  assign stall     = busy & (start | hilo_rd);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  // Sign correction; a zero divisor keeps the all-ones quotient untouched.
  always_comb begin
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] quo;
    logic [2*XLEN-1:0] rem;
    prod   = negate_if(acc, sign_a ^ sign_b);
    quo    = negate_if({{XLEN{1'b0}}, acc[XLEN-1:0]}, (sign_a ^ sign_b) && !div_zero);
    rem    = negate_if({{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}, sign_a);
    res_hi = is_div ? rem[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    res_lo = is_div ? quo[XLEN-1:0] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_MULT;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op_e'(op);
            sign_a   <= op_signed & rs_val[XLEN-1];
            sign_b   <= op_signed & rt_val[XLEN-1];
            div_zero <= (rt_val == '0);
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (flush)                         state <= IDLE;
          else if (cnt == CNT_W'(ITERS))     state <= FIX;
          else                               cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      operand <= op[1] ? mag_b : mag_a;
      acc     <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
    end else if (state == RUN && cnt != CNT_W'(ITERS)) begin
      acc <= acc_next;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic HI/LO reference.
module tb_muldiv_unit;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hilo_rd;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .hilo_rd (hilo_rd),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit signed/unsigned arithmetic; divide-by-zero rule applied explicitly.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: p = 64'b0;
    endcase
    if (o[1] == 1'b0) begin
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'b0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (o == 2'b10) begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  // Caller is positioned 1 time unit after a rising edge; start is sampled at the next edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; hilo_rd = 1'b1; flush = 1'b0;
    op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
    #2;
    n_checks++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    start = 1'b0; hilo_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [6];
    logic [31:0] t_a  [6];
    logic [31:0] t_b  [6];
    logic [31:0] t_hi [6];
    logic [31:0] t_lo [6];
    int cyc, bcyc;
    t_op[0] = 2'b01; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_hi[0] = 32'hFFFF_FFFE; t_lo[0] = 32'h0000_0001;
    t_op[1] = 2'b00; t_a[1] = 32'hFFFF_FFFD; t_b[1] = 32'd5;         t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hFFFF_FFF1;
    t_op[2] = 2'b10; t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;         t_hi[2] = 32'hFFFF_FFFF; t_lo[2] = 32'hFFFF_FFFD;
    t_op[3] = 2'b11; t_a[3] = 32'd7;         t_b[3] = 32'd2;         t_hi[3] = 32'd1;         t_lo[3] = 32'd3;
    t_op[4] = 2'b10; t_a[4] = 32'h1234_5678; t_b[4] = 32'd0;         t_hi[4] = 32'h1234_5678; t_lo[4] = 32'hFFFF_FFFF;
    t_op[5] = 2'b10; t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF; t_hi[5] = 32'd0;         t_lo[5] = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(cyc, bcyc);
      n_checks++; if (cyc !== 34)  begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 34", i, cyc); end
      n_checks++; if (bcyc !== 34) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d want 34", i, bcyc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); end
      n_checks++; if (hi !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, t_hi[i]); end
      n_checks++; if (lo !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, t_lo[i]); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    int cyc, bcyc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_model(o, a, b, eh, el);
      issue(o, a, b);
      wait_done(cyc, bcyc);
      n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 34", i, cyc); end
      n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, a, b, hi, eh); end
      n_checks++; if (lo !== el) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, a, b, lo, el); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] eh, el;
    int cyc, bcyc;
    issue(2'b11, 32'd1000, 32'd7);
    wait_done(cyc, bcyc);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
    ref_model(2'b00, 32'hFFFF_FF00, 32'h0001_0001, eh, el);
    issue(2'b00, 32'hFFFF_FF00, 32'h0001_0001);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
    n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL b2b_hi: got %h want %h", hi, eh); end
    n_checks++; if (lo !== el) begin n_fail++; $display("FAIL b2b_lo: got %h want %h", lo, el); end
  endtask

  task automatic test_flush;
    logic [31:0] h0, l0;
    int done_seen;
    h0 = hi; l0 = lo;
    issue(2'b11, 32'hDEAD_BEEF, 32'd13);
    repeat (9) begin @(posedge clk); #1; end
    hilo_rd = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_hilo: got %b want 1", stall); end
    hilo_rd = 1'b0; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_idle_inputs: got %b want 0", stall); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL flush_done_pulses: got %0d want 0", done_seen); end
    n_checks++; if (hi !== h0) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi, h0); end
    n_checks++; if (lo !== l0) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo, l0); end
  endtask

  task automatic test_ignored_start;
    int cyc, bcyc;
    issue(2'b01, 32'd2, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL busy_start_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL busy_start_lo: got %h want 00000006", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL busy_start_hi: got %h want 00000000", hi); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_relaunch: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc, bcyc;
    issue(2'b00, 32'h0012_3456, 32'hFFF0_0001);
    repeat (20) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL midrst_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL midrst_lo: got %h want 00000000", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b01, 32'd2, 32'd3);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL midrst_latency: got %0d want 34", cyc); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL midrst_lo_after: got %h want 00000006", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL midrst_hi_after: got %h want 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
